hazard_ctrl: RTL and testbench

//  Central stall/flush sequencer for the 5-stage pipeline. Drives the enable and clear

---
 rtl/hazard_pkg.sv | 21 ++
 rtl/hazard_perf_cnt.sv | 34 +++
 rtl/hazard_ctrl.sv | 118 +++++++++++
 tb/tb_hazard_ctrl.sv | 229 ++++++++++++++++++++++
 4 files changed

// File: rtl/hazard_pkg.sv
// Shared state encodings, constants and the load-use predicate for the hazard sequencer.
package hazard_pkg;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        DIV_BUSY  = 2'd1,
        EXC_FLUSH = 2'd2
    } state_e;

    localparam logic [4:0]  REG_ZERO = 5'd0;
    localparam int unsigned PERF_W   = 32;

    // A load in EX writes a register the instruction in ID is about to read.
    function automatic logic load_use(input logic       memread,
                                      input logic [4:0] wreg,
                                      input logic [4:0] rs,
                                      input logic [4:0] rt);
        return memread && (wreg != REG_ZERO) && ((wreg == rs) || (wreg == rt));
    endfunction

endpackage

// File: rtl/hazard_perf_cnt.sv
// Wrapping stall-cycle and flush-cycle event counters for the hazard sequencer.
module hazard_perf_cnt
    import hazard_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              stall_f_i,
    input  logic              flush_any_i,
    output logic [PERF_W-1:0] stall_cyc_o,
    output logic [PERF_W-1:0] flush_cnt_o
);

    logic [PERF_W-1:0] stall_cyc_q, stall_cyc_d;
    logic [PERF_W-1:0] flush_cnt_q, flush_cnt_d;

    always_comb begin
        stall_cyc_d = stall_cyc_q + PERF_W'(stall_f_i);
        flush_cnt_d = flush_cnt_q + PERF_W'(flush_any_i);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_cyc_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            stall_cyc_q <= stall_cyc_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    assign stall_cyc_o = stall_cyc_q;
    assign flush_cnt_o = flush_cnt_q;

endmodule

// File: rtl/hazard_ctrl.sv
// Stall/flush sequencer for the 5-stage pipeline: exceptions, divides, load-use and branches.
// Define HAZARD_PERF_EN to add the stall_cyc_o / flush_cnt_o performance counters.
module hazard_ctrl
    import hazard_pkg::*;
#(
    parameter int unsigned DIV_CYCLES = 36,
    parameter int unsigned CNT_W      = 6
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [4:0]       id_rs_i,
    input  logic [4:0]       id_rt_i,
    input  logic             ex_memread_i,
    input  logic [4:0]       ex_wreg_i,
    input  logic             branch_taken_i,
    input  logic             div_start_i,
    input  logic             exc_i,
    output logic             stall_f_o,
    output logic             stall_d_o,
    output logic             stall_e_o,
    output logic             flush_d_o,
    output logic             flush_e_o,
    output logic             flush_m_o,
    output logic             div_busy_o,
    output logic             div_done_o
`ifdef HAZARD_PERF_EN
    ,
    output logic [PERF_W-1:0] stall_cyc_o,
    output logic [PERF_W-1:0] flush_cnt_o
`endif
);

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Outputs are forced low while reset is held so the pipeline sees no stray stall/flush.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        stall_f_o  = 1'b0;
        stall_d_o  = 1'b0;
        stall_e_o  = 1'b0;
        flush_d_o  = 1'b0;
        flush_e_o  = 1'b0;
        flush_m_o  = 1'b0;
        div_busy_o = 1'b0;
        div_done_o = 1'b0;
        if (!rst) begin
            div_busy_o = (state_q == DIV_BUSY);
            if (exc_i) begin
                flush_d_o = 1'b1;
                flush_e_o = 1'b1;
                flush_m_o = 1'b1;
                cnt_d     = '0;
                state_d   = EXC_FLUSH;
            end else begin
                case (state_q)
                    EXC_FLUSH: begin
                        flush_d_o = 1'b1;
                        state_d   = IDLE;
                    end
                    DIV_BUSY: begin
                        stall_f_o = 1'b1;
                        stall_d_o = 1'b1;
                        stall_e_o = 1'b1;
                        flush_m_o = 1'b1;
                        cnt_d     = cnt_q - CNT_W'(1);
                        if (cnt_q == '0) begin
                            div_done_o = 1'b1;
                            cnt_d      = '0;
                            state_d    = IDLE;
                        end
                    end
                    default: begin
                        if (div_start_i) begin
                            stall_f_o = 1'b1;
                            stall_d_o = 1'b1;
                            stall_e_o = 1'b1;
                            flush_m_o = 1'b1;
                            cnt_d     = CNT_W'(DIV_CYCLES - 2);
                            state_d   = DIV_BUSY;
                        end else if (load_use(ex_memread_i, ex_wreg_i, id_rs_i, id_rt_i)) begin
                            stall_f_o = 1'b1;
                            stall_d_o = 1'b1;
                            flush_e_o = 1'b1;
                        end else if (branch_taken_i) begin
                            flush_d_o = 1'b1;
                        end
                    end
                endcase
            end
        end
    end

`ifdef HAZARD_PERF_EN
    hazard_perf_cnt u_perf (
        .clk         (clk),
        .rst         (rst),
        .stall_f_i   (stall_f_o),
        .flush_any_i (flush_d_o | flush_e_o | flush_m_o),
        .stall_cyc_o (stall_cyc_o),
        .flush_cnt_o (flush_cnt_o)
    );
`else
    // Counters are absent in this build; nothing further to drive.
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// Self-checking bench for hazard_ctrl (DIV_CYCLES=4): directed scenarios plus random traffic vs a model.
module tb_hazard_ctrl;

    localparam int unsigned DIVC = 4;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [4:0] id_rs = '0, id_rt = '0, ex_wreg = '0;
    logic       ex_memread = 1'b0, branch_taken = 1'b0, div_start = 1'b0, exc = 1'b0;
    logic       stall_f, stall_d, stall_e, flush_d, flush_e, flush_m, div_busy, div_done;
`ifdef HAZARD_PERF_EN
    logic [31:0] stall_cyc, flush_cnt;
`endif

    int n_checks = 0;
    int n_errs   = 0;

    // Model state: remaining divide stall cycles and a pending post-exception fetch drop.
    int       m_div_left = 0;
    bit       m_exc_after = 1'b0;
    int       nxt_div_left = 0;
    bit       nxt_exc_after = 1'b0;
    bit       m_cnt_stall = 1'b0, m_cnt_flush = 1'b0;
    longint   m_stall_cyc = 0, m_flush_cnt = 0;

    always #5 clk = ~clk;

    hazard_ctrl #(.DIV_CYCLES(DIVC)) dut (
        .clk            (clk),
        .rst            (rst),
        .id_rs_i        (id_rs),
        .id_rt_i        (id_rt),
        .ex_memread_i   (ex_memread),
        .ex_wreg_i      (ex_wreg),
        .branch_taken_i (branch_taken),
        .div_start_i    (div_start),
        .exc_i          (exc),
        .stall_f_o      (stall_f),
        .stall_d_o      (stall_d),
        .stall_e_o      (stall_e),
        .flush_d_o      (flush_d),
        .flush_e_o      (flush_e),
        .flush_m_o      (flush_m),
        .div_busy_o     (div_busy),
        .div_done_o     (div_done)
`ifdef HAZARD_PERF_EN
        ,
        .stall_cyc_o    (stall_cyc),
        .flush_cnt_o    (flush_cnt)
`endif
    );

    function automatic logic [7:0] outs();
        return {stall_f, stall_d, stall_e, flush_d, flush_e, flush_m, div_busy, div_done};
    endfunction

    // Reference: outputs as {stall_f,stall_d,stall_e,flush_d,flush_e,flush_m,div_busy,div_done}.
    always @(negedge clk) begin
        logic [7:0] exp_v;
        logic [7:0] got_v;
        int         nd;
        bit         ne;
        bit         lu;
        exp_v = 8'h00;
        nd    = m_div_left;
        ne    = 1'b0;
        lu    = ex_memread && (ex_wreg != 5'd0) && (ex_wreg == id_rs || ex_wreg == id_rt);
        if (rst) begin
            nd = 0;
        end else if (exc) begin
            exp_v = {3'b000, 3'b111, (m_div_left > 0), 1'b0};
            nd    = 0;
            ne    = 1'b1;
        end else if (m_exc_after) begin
            exp_v = 8'b000_100_00;
        end else if (m_div_left > 0) begin
            exp_v = {3'b111, 3'b001, 1'b1, (m_div_left == 1)};
            nd    = m_div_left - 1;
        end else if (div_start) begin
            exp_v = 8'b111_001_00;
            nd    = int'(DIVC) - 1;
        end else if (lu) begin
            exp_v = 8'b110_010_00;
        end else if (branch_taken) begin
            exp_v = 8'b000_100_00;
        end
        got_v = outs();
        n_checks++;
        if (got_v !== exp_v) begin
            n_errs++;
            $display("FAIL model_outputs t=%0t actual=%b required=%b", $time, got_v, exp_v);
        end
        n_checks++;
        if ((got_v[6] & got_v[4]) | (got_v[5] & got_v[3])) begin
            n_errs++;
            $display("FAIL stall_flush_same_stage t=%0t actual=%b required=no overlap", $time, got_v);
        end
`ifdef HAZARD_PERF_EN
        n_checks++;
        if (stall_cyc !== 32'(m_stall_cyc) || flush_cnt !== 32'(m_flush_cnt)) begin
            n_errs++;
            $display("FAIL perf_model t=%0t actual=%0d/%0d required=%0d/%0d", $time,
                     stall_cyc, flush_cnt, 32'(m_stall_cyc), 32'(m_flush_cnt));
        end
`endif
        nxt_div_left  <= nd;
        nxt_exc_after <= ne;
        m_cnt_stall   <= exp_v[7];
        m_cnt_flush   <= |exp_v[4:2];
    end

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_div_left  <= 0;
            m_exc_after <= 1'b0;
            m_stall_cyc <= 0;
            m_flush_cnt <= 0;
        end else begin
            m_div_left  <= nxt_div_left;
            m_exc_after <= nxt_exc_after;
            m_stall_cyc <= m_stall_cyc + longint'(m_cnt_stall);
            m_flush_cnt <= m_flush_cnt + longint'(m_cnt_flush);
        end
    end

    task automatic chk(input string name, input logic [7:0] got, input logic [7:0] req);
        n_checks++;
        if (got !== req) begin
            n_errs++;
            $display("FAIL %s t=%0t actual=%b required=%b", name, $time, got, req);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        id_rs = '0; id_rt = '0; ex_wreg = '0;
        ex_memread = 1'b0; branch_taken = 1'b0; div_start = 1'b0; exc = 1'b0;
    endtask

    initial begin
        // Reset holds every output low even with active hazard inputs.
        branch_taken = 1'b1; div_start = 1'b1; exc = 1'b1;
        @(negedge clk);
        chk("reset_outputs", outs(), 8'h00);
        idle_inputs();
        step();
        rst = 1'b0;
        @(negedge clk); chk("idle_after_reset", outs(), 8'h00);

        // Divide: four stall cycles, done only in the last.
        step(); div_start = 1'b1;
        @(negedge clk); chk("div_issue", outs(), 8'b111_001_00);
        step(); div_start = 1'b0;
        @(negedge clk); chk("div_busy1", outs(), 8'b111_001_10);
        step(); @(negedge clk); chk("div_busy2", outs(), 8'b111_001_10);
        step(); @(negedge clk); chk("div_done", outs(), 8'b111_001_11);
        step(); @(negedge clk); chk("div_back_idle", outs(), 8'h00);
`ifdef HAZARD_PERF_EN
        n_checks++;
        if (stall_cyc !== 32'd4 || flush_cnt !== 32'd4) begin
            n_errs++;
            $display("FAIL perf_div t=%0t actual=%0d/%0d required=4/4", $time, stall_cyc, flush_cnt);
        end
`endif

        // Load-use, then the same with r0 as the load destination.
        step(); ex_memread = 1'b1; ex_wreg = 5'd8; id_rs = 5'd8; id_rt = 5'd3;
        @(negedge clk); chk("load_use", outs(), 8'b110_010_00);
        step(); ex_memread = 1'b0;
        @(negedge clk); chk("load_use_cleared", outs(), 8'h00);
        step(); ex_memread = 1'b1; ex_wreg = 5'd0; id_rs = 5'd0;
        @(negedge clk); chk("load_use_r0", outs(), 8'h00);

        // Exception in the first busy cycle aborts the divide.
        step(); idle_inputs(); div_start = 1'b1;
        @(negedge clk); chk("exc_div_issue", outs(), 8'b111_001_00);
        step(); div_start = 1'b0; exc = 1'b1;
        @(negedge clk); chk("exc_flush_all", outs(), 8'b000_111_10);
        step(); exc = 1'b0;
        @(negedge clk); chk("exc_flush_d", outs(), 8'b000_100_00);
        step(); @(negedge clk); chk("exc_idle", outs(), 8'h00);
        step(); @(negedge clk); chk("exc_no_done", outs(), 8'h00);

        // Branch concurrent with load-use: stall wins, branch taken next cycle.
        step(); ex_memread = 1'b1; ex_wreg = 5'd5; id_rs = 5'd1; id_rt = 5'd5; branch_taken = 1'b1;
        @(negedge clk); chk("branch_vs_load_use", outs(), 8'b110_010_00);
        step(); ex_memread = 1'b0;
        @(negedge clk); chk("branch_retry", outs(), 8'b000_100_00);

        // Reset in the second busy cycle clears outputs immediately.
        step(); idle_inputs(); div_start = 1'b1;
        @(negedge clk); chk("rst_div_issue", outs(), 8'b111_001_00);
        step(); div_start = 1'b0;
        @(negedge clk); chk("rst_div_busy1", outs(), 8'b111_001_10);
        step(); #1 rst = 1'b1; #1;
        chk("rst_async_outputs", outs(), 8'h00);
        step(); rst = 1'b0;
        @(negedge clk); chk("rst_release_idle", outs(), 8'h00);
        step(); div_start = 1'b1;
        @(negedge clk); chk("rst_then_issue", outs(), 8'b111_001_00);
        step(); idle_inputs();
        repeat (DIVC) step();

        // Random traffic; the compare process checks every cycle.
        for (int i = 0; i < 4000; i++) begin
            step();
            rst          = ($urandom_range(0, 249) == 0);
            exc          = ($urandom_range(0, 19) == 0);
            div_start    = ($urandom_range(0, 9) == 0);
            ex_memread   = ($urandom_range(0, 1) == 1);
            ex_wreg      = 5'($urandom_range(0, 3));
            id_rs        = 5'($urandom_range(0, 3));
            id_rt        = 5'($urandom_range(0, 3));
            branch_taken = ($urandom_range(0, 2) == 0);
        end
        step();
        rst = 1'b0;
        idle_inputs();
        repeat (DIVC + 2) step();

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errs);
        $finish;
    end

endmodule
